mem_port_sched: RTL and testbench
=================================

# mem_port_sched

Sequencer for a single-ported unified instruction/data memory shared by the fetch stage and the MEM stage of the five-stage pipeline. Arbitrates fetch and load/store requests onto one memory handshake, waits out variable memory latency, and drives a pipeline-wide stall until every request of the current pipeline cycle has completed. Sits between the pipeline latches (FL/FD/DE/EM/MW enables) and the memory.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch request, held while `pipe_stall`
- `if_adr`  in  AW  fetch address (PC)
- `if_rdata`  out  DW  fetched instruction, registered, held until next fetch completes
- `dm_read` / `dm_write`  in  1  load / store request from MEM stage (mutually exclusive)
- `dm_adr`  in  AW  data address
- `dm_wdata`  in  DW  store data
- `dm_rdata`  out  DW  load data, registered, held until next load completes
- `pipe_stall`  out  1  freeze all pipeline latches this cycle
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1 = write
- `mem_adr`  out  AW  memory address, registered
- `mem_wdata`  out  DW  memory write data, registered
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion from memory

## Operation
- FSM states: IDLE, D_WAIT, F_WAIT, RESP.
- Sticky flags `d_done`, `f_done`; `d_pend = dm_read|dm_write`, `f_pend = if_req`.
- `pipe_stall = (d_pend & ~d_done) | (f_pend & ~f_done)`, combinational from registered flags and live requests.
- IDLE: if `d_pend & ~d_done` → load `mem_req=1`, `mem_we=dm_write`, `mem_adr=dm_adr`, `mem_wdata=dm_wdata`; go D_WAIT. Else if `f_pend & ~f_done` → `mem_req=1`, `mem_we=0`, `mem_adr=if_adr`; go F_WAIT. Data has fixed priority (older instruction).
- D_WAIT/F_WAIT: hold `mem_req`, `mem_we`, `mem_adr`, `mem_wdata` stable until `mem_ack`. On ack: drop `mem_req`; D_WAIT captures `mem_rdata` into `dm_rdata` if load (store leaves `dm_rdata` unchanged), sets `d_done`; F_WAIT captures into `if_rdata`, sets `f_done`; go RESP.
- RESP: one idle cycle, no new request issued; go IDLE.
- Flags clear on any edge where `pipe_stall=0` (pipeline advances); clearing has priority over no-op, never coincides with set (set only occurs while stalled).
- `mem_ack` outside D_WAIT/F_WAIT ignored.
- Reset (any time, including mid-transaction): state IDLE, `mem_req=0`, `mem_we=0`, `mem_adr=0`, `mem_wdata=0`, `if_rdata=0`, `dm_rdata=0`, flags 0; outstanding memory access abandoned, late ack ignored.

## Timing
- Memory ack earliest in first cycle `mem_req` is high.
- Single access, ack latency L≥1: request seen cycle 0, `mem_req` high cycles 1..L, RESP cycle L+1, `pipe_stall` low in cycle L+1 (flag set at end of L), pipeline advances at end of L+1. Stall duration L+1 cycles.
- Fetch + data same cycle: data first, then fetch; total stall = (Ld+2)+(Lf+1) cycles, with fetch issued from IDLE the cycle after data's RESP.
- `pipe_stall` high in cycle 0 whenever any request is pending and not done; no pipeline cycle completes without a memory access (absent buffer hit).

## Configuration
- `MEM_SCHED_IBUF_EN` defined: one-entry fetch buffer (tag `AW`, data `DW`, valid). In IDLE, `f_pend & ~f_done & valid & tag==if_adr` (and no data request pending) → load `if_rdata` from buffer, set `f_done`, go RESP without `mem_req`. Buffer filled on every F_WAIT ack; invalidated by reset and by any completed store.
- Undefined: no buffer; every fetch accesses memory.

## Test plan
- Reset: assert `rst=0` mid D_WAIT with `mem_req=1` → next cycle all outputs 0, ack arriving later ignored, state IDLE.
- Lone fetch, `if_adr=0x40`, ack after 3 cycles with `0x8C220004` → `mem_req` high cycles 1–3, `if_rdata=0x8C220004` cycle 4, `pipe_stall` high cycles 0–3, low cycle 4.
- Simultaneous `dm_write` (adr 0x100, data 0xDEADBEEF) and fetch 0x44, both L=1 → memory sees write first (`mem_we=1`), then read of 0x44; `pipe_stall` low only after fetch RESP (5 stall cycles).
- Load 0x200 L=2 returning 0x12345678 → `dm_rdata=0x12345678`, held unchanged through following store.
- Spurious `mem_ack` in IDLE → no state change, no flag set, outputs unchanged.
- `MEM_SCHED_IBUF_EN`: fetch 0x48 twice across a hazard freeze → second completes with no `mem_req`, 1 stall cycle; intervening store → refetch from memory.

Source files
------------

// File: rtl/mem_port_sched_if.sv
// mem_port_sched_if: pipeline-side requests/responses and memory handshake of the shared memory port.
interface mem_port_sched_if #(parameter int AW = 32, parameter int DW = 32);
  logic          if_req;
  logic [AW-1:0] if_adr;
  logic [DW-1:0] if_rdata;
  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_adr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          pipe_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  modport master(
    input  if_req, if_adr, dm_read, dm_write, dm_adr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, dm_rdata, pipe_stall, mem_req, mem_we, mem_adr, mem_wdata
  );
  modport slave(
    output if_req, if_adr, dm_read, dm_write, dm_adr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, dm_rdata, pipe_stall, mem_req, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/mem_port_sched.sv
// mem_port_sched: arbitrates fetch and load/store onto one memory port, stalling the pipeline until both complete.
// Define MEM_SCHED_IBUF_EN to add a one-entry fetch buffer that skips memory on a repeated fetch address.
module mem_port_sched #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst,
  mem_port_sched_if.master bus
);
  typedef enum logic [1:0] {IDLE, D_WAIT, F_WAIT, RESP} state_t;
  state_t state;
  logic d_done, f_done, d_need, f_need;
  assign d_need = (bus.dm_read | bus.dm_write) & ~d_done;
  assign f_need = bus.if_req & ~f_done;
  assign bus.pipe_stall = d_need | f_need;
`ifdef MEM_SCHED_IBUF_EN
  logic          buf_valid;
  logic [AW-1:0] buf_tag;
  logic [DW-1:0] buf_data;
  logic          buf_hit;
  assign buf_hit = buf_valid && buf_tag == bus.if_adr;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      d_done        <= 1'b0;
      f_done        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_adr   <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
`ifdef MEM_SCHED_IBUF_EN
      buf_valid     <= 1'b0;
      buf_tag       <= '0;
      buf_data      <= '0;
`endif
    end else begin
      case (state)
        IDLE:
          if (d_need) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_write;
            bus.mem_adr   <= bus.dm_adr;
            bus.mem_wdata <= bus.dm_wdata;
            state         <= D_WAIT;
          end
`ifdef MEM_SCHED_IBUF_EN
          else if (f_need && buf_hit) begin
            bus.if_rdata <= buf_data;
            f_done       <= 1'b1;
            state        <= RESP;
          end
`endif
          else if (f_need) begin
            bus.mem_req <= 1'b1;
            bus.mem_we  <= 1'b0;
            bus.mem_adr <= bus.if_adr;
            state       <= F_WAIT;
          end
        D_WAIT:
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
`ifdef MEM_SCHED_IBUF_EN
            if (bus.mem_we) buf_valid <= 1'b0;
`endif
            d_done <= 1'b1;
            state  <= RESP;
          end
        F_WAIT:
          if (bus.mem_ack) begin
            bus.mem_req  <= 1'b0;
            bus.if_rdata <= bus.mem_rdata;
`ifdef MEM_SCHED_IBUF_EN
            buf_valid    <= 1'b1;
            buf_tag      <= bus.mem_adr;
            buf_data     <= bus.mem_rdata;
`endif
            f_done <= 1'b1;
            state  <= RESP;
          end
        default: state <= IDLE;
      endcase
      // an advancing pipeline starts a fresh cycle of requests
      if (!bus.pipe_stall) begin
        d_done <= 1'b0;
        f_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: directed vectors with hand-computed expectations for mem_port_sched.
module tb_mem_port_sched;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int n_stall;
  always #5 clk = ~clk;
  mem_port_sched_if #(.AW(32), .DW(32)) bus();
  mem_port_sched #(.AW(32), .DW(32)) dut(.clk(clk), .rst(rst), .bus(bus.master));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic idle_in();
    bus.if_req = 0; bus.dm_read = 0; bus.dm_write = 0; bus.mem_ack = 0;
  endtask
  initial begin
    rst = 0;
    bus.if_adr = 0; bus.dm_adr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0;
    idle_in();
    nxt(); nxt(); smp();
    chk("rst_req", bus.mem_req, 0);
    chk("rst_adr", bus.mem_adr, 0);
    chk("rst_ifd", bus.if_rdata, 0);
    chk("rst_dmd", bus.dm_rdata, 0);
    chk("rst_stall", bus.pipe_stall, 0);
    nxt(); rst = 1;
    // lone fetch 0x40, L=3
    nxt(); bus.if_req = 1; bus.if_adr = 32'h40; smp();
    chk("f_c0_stall", bus.pipe_stall, 1);
    chk("f_c0_req", bus.mem_req, 0);
    for (int c = 1; c <= 3; c++) begin
      nxt(); bus.mem_ack = (c == 3); bus.mem_rdata = (c == 3) ? 32'h8C220004 : 32'h0; smp();
      chk("f_req", bus.mem_req, 1);
      chk("f_adr", bus.mem_adr, 32'h40);
      chk("f_we", bus.mem_we, 0);
      chk("f_stall", bus.pipe_stall, 1);
    end
    nxt(); bus.mem_ack = 0; smp();
    chk("f_c4_req", bus.mem_req, 0);
    chk("f_c4_ifd", bus.if_rdata, 32'h8C220004);
    chk("f_c4_stall", bus.pipe_stall, 0);
    nxt(); idle_in(); smp();
    chk("f_c5_stall", bus.pipe_stall, 0);
    // store 0x100 + fetch 0x44, both L=1
    n_stall = 0;
    nxt(); bus.dm_write = 1; bus.dm_adr = 32'h100; bus.dm_wdata = 32'hDEADBEEF;
    bus.if_req = 1; bus.if_adr = 32'h44;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) nxt();
      bus.mem_ack = (c == 1 || c == 4);
      bus.mem_rdata = (c == 1) ? 32'hBAD0BAD0 : (c == 4) ? 32'h20010005 : 32'h0;
      smp();
      if (bus.pipe_stall) n_stall++;
      chk("sf_stall", bus.pipe_stall, (c < 5) ? 1 : 0);
      chk("sf_req", bus.mem_req, (c == 1 || c == 4) ? 1 : 0);
      if (c == 1) begin
        chk("sf_we_st", bus.mem_we, 1);
        chk("sf_adr_st", bus.mem_adr, 32'h100);
        chk("sf_wd_st", bus.mem_wdata, 32'hDEADBEEF);
      end
      if (c == 4) begin
        chk("sf_we_f", bus.mem_we, 0);
        chk("sf_adr_f", bus.mem_adr, 32'h44);
      end
    end
    chk("sf_nstall", n_stall, 5);
    chk("sf_ifd", bus.if_rdata, 32'h20010005);
    chk("sf_dmd", bus.dm_rdata, 0);
    nxt(); idle_in(); smp();
    // load 0x200 L=2, then store 0x204 L=1
    nxt(); bus.dm_read = 1; bus.dm_adr = 32'h200; smp();
    chk("ld_c0_stall", bus.pipe_stall, 1);
    nxt(); smp();
    chk("ld_c1_req", bus.mem_req, 1);
    chk("ld_c1_we", bus.mem_we, 0);
    chk("ld_c1_adr", bus.mem_adr, 32'h200);
    nxt(); bus.mem_ack = 1; bus.mem_rdata = 32'h12345678; smp();
    chk("ld_c2_stall", bus.pipe_stall, 1);
    nxt(); bus.mem_ack = 0; bus.mem_rdata = 0; smp();
    chk("ld_c3_dmd", bus.dm_rdata, 32'h12345678);
    chk("ld_c3_stall", bus.pipe_stall, 0);
    nxt(); bus.dm_read = 0; bus.dm_write = 1; bus.dm_adr = 32'h204; bus.dm_wdata = 32'hCAFEF00D; smp();
    chk("st_c0_stall", bus.pipe_stall, 1);
    nxt(); bus.mem_ack = 1; bus.mem_rdata = 32'h55555555; smp();
    chk("st_c1_we", bus.mem_we, 1);
    nxt(); bus.mem_ack = 0; smp();
    chk("st_c2_stall", bus.pipe_stall, 0);
    chk("st_c2_dmd", bus.dm_rdata, 32'h12345678);
    nxt(); idle_in(); smp();
    // spurious ack in IDLE, then a fetch must issue with normal latency
    nxt(); bus.mem_ack = 1; bus.mem_rdata = 32'hFFFFFFFF; smp();
    chk("sp_stall", bus.pipe_stall, 0);
    nxt(); bus.mem_ack = 0; smp();
    chk("sp_req", bus.mem_req, 0);
    chk("sp_ifd", bus.if_rdata, 32'h20010005);
    chk("sp_dmd", bus.dm_rdata, 32'h12345678);
    bus.if_req = 1; bus.if_adr = 32'h80;
    nxt(); smp();
    chk("sp_f_req", bus.mem_req, 1);
    chk("sp_f_adr", bus.mem_adr, 32'h80);
    nxt(); bus.mem_ack = 1; bus.mem_rdata = 32'h0000ABCD; smp();
    nxt(); bus.mem_ack = 0; smp();
    chk("sp_f_ifd", bus.if_rdata, 32'h0000ABCD);
    nxt(); idle_in(); smp();
    // reset mid D_WAIT, late ack ignored
    nxt(); bus.dm_read = 1; bus.dm_adr = 32'h300; smp();
    nxt(); smp();
    chk("rm_req_pre", bus.mem_req, 1);
    rst = 0; bus.dm_read = 0; #1;
    chk("rm_req", bus.mem_req, 0);
    chk("rm_adr", bus.mem_adr, 0);
    chk("rm_dmd", bus.dm_rdata, 0);
    chk("rm_ifd", bus.if_rdata, 0);
    nxt(); rst = 1;
    bus.mem_ack = 1; bus.mem_rdata = 32'h77777777; smp();
    nxt(); bus.mem_ack = 0; smp();
    chk("rm_late_req", bus.mem_req, 0);
    chk("rm_late_dmd", bus.dm_rdata, 0);
    chk("rm_late_stall", bus.pipe_stall, 0);
`ifdef MEM_SCHED_IBUF_EN
    // fetch 0x48 from memory, repeat it from the buffer, store, then refetch from memory
    nxt(); bus.if_req = 1; bus.if_adr = 32'h48; smp();
    nxt(); bus.mem_ack = 1; bus.mem_rdata = 32'h01234567; smp();
    chk("ib_f1_req", bus.mem_req, 1);
    nxt(); bus.mem_ack = 0; smp();
    chk("ib_f1_stall", bus.pipe_stall, 0);
    nxt(); smp();
    chk("ib_f2_stall", bus.pipe_stall, 1);
    nxt(); smp();
    chk("ib_f2_req", bus.mem_req, 0);
    chk("ib_f2_stall1", bus.pipe_stall, 0);
    chk("ib_f2_ifd", bus.if_rdata, 32'h01234567);
    nxt(); bus.if_req = 0; bus.dm_write = 1; bus.dm_adr = 32'h48; bus.dm_wdata = 32'h89ABCDEF; smp();
    nxt(); bus.mem_ack = 1; smp();
    nxt(); bus.mem_ack = 0; smp();
    nxt(); bus.dm_write = 0; bus.if_req = 1; smp();
    nxt(); smp();
    chk("ib_f3_req", bus.mem_req, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h89ABCDEF;
    nxt(); bus.mem_ack = 0; smp();
    chk("ib_f3_ifd", bus.if_rdata, 32'h89ABCDEF);
    nxt(); idle_in(); smp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
